// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI burst/response encodings, slave FSM states and arbitration tags.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axi_pkg;

  // Default AxLEN width. The beat counter is one bit wider so over-long write bursts still count.
  localparam int AXI_LEN_W = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RDATA = 2'd1,
    ST_WDATA = 2'd2,
    ST_WRESP = 2'd3
  } state_e;

  // Records which transaction type won the most recent arbitration.
  typedef enum logic {
    GRANT_READ  = 1'b0,
    GRANT_WRITE = 1'b1
  } grant_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: next SRAM word address for a burst beat, plus unsupported-burst flag.
// Latency: combinational.
// Backpressure: none; the caller decides when to advance.
// Ports: addr/burst in; next_addr (wraps mod 2^AW) and burst_err out.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic [AW-1:0] addr,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr,
  output logic          burst_err
);

  always_comb begin
    next_addr = addr + {{(AW-1){1'b0}}, 1'b1};
    burst_err = 1'b0;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  burst_err = 1'b0;
      // WRAP and the reserved encoding walk like INCR but get flagged so the response is SLVERR.
      default:     burst_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave serialising AR/R and AW/W/B bursts onto one single-port SRAM bank.
// Latency: first R beat 1 cycle after AR accept, then 1 beat/cycle; B one cycle after WLAST accept.
// Backpressure: RREADY low holds the address and re-reads the SRAM; BREADY low holds B; one burst in flight.
// Ports: ACLK/ARESETn; AXI4 AW/W/B and AR/R channels; SRAM_* macro port (active-low CEB/WEB/BWEB, DO 1 cycle after A).
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int ID_W    = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = AXI_LEN_W,
  parameter int SRAM_AW = 14
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     AWID,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [LEN_W-1:0]    AWLEN,
  input  logic [2:0]          AWSIZE,
  input  logic [1:0]          AWBURST,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WLAST,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [ID_W-1:0]     BID,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ID_W-1:0]     ARID,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [LEN_W-1:0]    ARLEN,
  input  logic [2:0]          ARSIZE,
  input  logic [1:0]          ARBURST,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [ID_W-1:0]     RID,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RLAST,
  output logic                RVALID,
  input  logic                RREADY,
  output logic                SRAM_CEB,
  output logic                SRAM_WEB,
  output logic [DATA_W-1:0]   SRAM_BWEB,
  output logic [SRAM_AW-1:0]  SRAM_A,
  output logic [DATA_W-1:0]   SRAM_DI,
  input  logic [DATA_W-1:0]   SRAM_DO
);

  localparam int CNT_W = LEN_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e             state_q, state_d;
  grant_e             last_grant_q, last_grant_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [1:0]         burst_q, burst_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [SRAM_AW-1:0] next_addr;
  logic               burst_err;
  logic               grant_r, grant_w;
  logic               last_beat;

  // Size is ignored and address bits outside the bank select nothing here.
  logic unused_ok;
  assign unused_ok = ^{ARSIZE, AWSIZE, ARADDR[1:0], AWADDR[1:0],
                       ARADDR[ADDR_W-1:SRAM_AW+2], AWADDR[ADDR_W-1:SRAM_AW+2]};

  axi_burst_addr_gen #(.AW(SRAM_AW)) u_addr_gen (
    .addr      (addr_q),
    .burst     (burst_q),
    .next_addr (next_addr),
    .burst_err (burst_err)
  );

  // On a tie the type not served last wins; qualifying with ARESETn keeps both READYs and
  // the SRAM quiet while reset is held.
  assign grant_w   = ARESETn & AWVALID & (~ARVALID | (last_grant_q == GRANT_READ));
  assign grant_r   = ARESETn & ARVALID & ~grant_w;
  assign last_beat = (cnt_q == {1'b0, len_q});

  assign RID   = id_q;
  assign BID   = id_q;
  assign RDATA = SRAM_DO;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    len_d        = len_q;
    burst_d      = burst_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    ARREADY      = 1'b0;
    AWREADY      = 1'b0;
    WREADY       = 1'b0;
    RVALID       = 1'b0;
    RLAST        = 1'b0;
    RRESP        = RESP_OKAY;
    BVALID       = 1'b0;
    BRESP        = RESP_OKAY;
    SRAM_CEB     = 1'b1;
    SRAM_WEB     = 1'b1;
    SRAM_BWEB    = '1;
    SRAM_A       = addr_q;
    SRAM_DI      = '0;

    case (state_q)
      ST_IDLE: begin
        ARREADY = grant_r;
        AWREADY = grant_w;
        if (grant_r) begin
          id_d         = ARID;
          len_d        = ARLEN;
          burst_d      = ARBURST;
          addr_d       = ARADDR[SRAM_AW+1:2];
          cnt_d        = '0;
          last_grant_d = GRANT_READ;
          // Start the first SRAM read now so beat 0 is on DO next cycle.
          SRAM_A       = ARADDR[SRAM_AW+1:2];
          SRAM_CEB     = 1'b0;
          state_d      = ST_RDATA;
        end else if (grant_w) begin
          id_d         = AWID;
          len_d        = AWLEN;
          burst_d      = AWBURST;
          addr_d       = AWADDR[SRAM_AW+1:2];
          cnt_d        = '0;
          last_grant_d = GRANT_WRITE;
          state_d      = ST_WDATA;
        end
      end

      ST_RDATA: begin
        RVALID   = 1'b1;
        RLAST    = last_beat;
        RRESP    = burst_err ? RESP_SLVERR : RESP_OKAY;
        // Stalled: keep reading the same word so DO stays stable.
        SRAM_CEB = 1'b0;
        if (RREADY) begin
          if (last_beat) begin
            SRAM_CEB = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            // Fetch the next beat underneath the accepted one for 1 beat/cycle.
            SRAM_A = next_addr;
            addr_d = next_addr;
            cnt_d  = cnt_q + CNT_ONE;
          end
        end
      end

      ST_WDATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          SRAM_CEB = ~(|WSTRB);
          SRAM_WEB = 1'b0;
          SRAM_DI  = WDATA;
          for (int b = 0; b < DATA_W/8; b++) begin
            SRAM_BWEB[8*b +: 8] = {8{~WSTRB[b]}};
          end
          addr_d = next_addr;
          // Saturate so a runaway burst cannot alias back onto LEN+1.
          cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
          if (WLAST) begin
            state_d = ST_WRESP;
          end
        end
      end

      ST_WRESP: begin
        BVALID = 1'b1;
        BRESP  = ((cnt_q == ({1'b0, len_q} + CNT_ONE)) && !burst_err) ? RESP_OKAY : RESP_SLVERR;
        if (BREADY) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_READ;
      id_q         <= '0;
      len_q        <= '0;
      burst_q      <= BURST_INCR;
      addr_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      len_q        <= len_d;
      burst_q      <= burst_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed, table-driven bench for axi_sram_slave with a behavioural SRAM.
// Latency: n/a.
// Backpressure: bench drives RREADY/BREADY stalls explicitly.
module tb_axi_sram_slave;

  localparam int DEPTH = 16384;

  logic        ACLK, ARESETn;
  logic [7:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [3:0]  AWLEN, ARLEN, WSTRB;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic        SRAM_CEB, SRAM_WEB;
  logic [31:0] SRAM_BWEB, SRAM_DI, SRAM_DO;
  logic [13:0] SRAM_A;

  logic [31:0] sram    [0:DEPTH-1];
  logic [31:0] exp_mem [0:DEPTH-1];
  logic        mem_init, bd_we;
  logic [13:0] bd_addr;
  logic [31:0] bd_dat;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    bit          wr;
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [1:0]  burst;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } vec_t;

  vec_t vecs [9];

  axi_sram_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .SRAM_CEB(SRAM_CEB), .SRAM_WEB(SRAM_WEB), .SRAM_BWEB(SRAM_BWEB), .SRAM_A(SRAM_A),
    .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 ^ 32'(i);
  endfunction

  // Behavioural single-port SRAM: per-bit active-low write enable, registered read.
  always @(posedge ACLK) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= pat(i);
    end else if (bd_we) begin
      sram[bd_addr] <= bd_dat;
    end else if (!SRAM_CEB) begin
      if (!SRAM_WEB) sram[SRAM_A] <= (sram[SRAM_A] & SRAM_BWEB) | (SRAM_DI & ~SRAM_BWEB);
      else           SRAM_DO <= sram[SRAM_A];
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  function automatic logic sel_sig(input int which);
    case (which)
      0: return ARREADY;
      1: return AWREADY;
      2: return WREADY;
      3: return RVALID;
      4: return BVALID;
      default: return 1'b0;
    endcase
  endfunction

  // Returns at a negedge with the selected signal high (or after the budget expires).
  task automatic wait_for(input int which, input string name, output int waited);
    waited = 0;
    @(negedge ACLK);
    while (sel_sig(which) !== 1'b1 && waited < 50) begin
      @(negedge ACLK);
      waited++;
    end
    chk(name, 64'(sel_sig(which)), 64'd1);
  endtask

  function automatic logic [13:0] nxt(input logic [13:0] w, input logic [1:0] burst);
    return (burst == 2'b00) ? w : w + 14'd1;
  endfunction

  task automatic chk_rst(input string tag);
    chk({tag, " arready"}, 64'(ARREADY), 64'd0);
    chk({tag, " awready"}, 64'(AWREADY), 64'd0);
    chk({tag, " wready"},  64'(WREADY),  64'd0);
    chk({tag, " rvalid"},  64'(RVALID),  64'd0);
    chk({tag, " bvalid"},  64'(BVALID),  64'd0);
    chk({tag, " bresp"},   64'(BRESP),   64'd0);
    chk({tag, " rresp"},   64'(RRESP),   64'd0);
    chk({tag, " rlast"},   64'(RLAST),   64'd0);
    chk({tag, " bid"},     64'(BID),     64'd0);
    chk({tag, " rid"},     64'(RID),     64'd0);
    chk({tag, " ceb"},     64'(SRAM_CEB), 64'd1);
    chk({tag, " web"},     64'(SRAM_WEB), 64'd1);
    chk({tag, " bweb"},    64'(SRAM_BWEB), 64'hFFFF_FFFF);
  endtask

  task automatic do_read(input string tag, input logic [7:0] id, input logic [31:0] addr,
                         input logic [3:0] len, input logic [1:0] burst, input logic [1:0] resp);
    int n;
    logic [13:0] w;
    ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1; RREADY = 1'b1;
    wait_for(0, {tag, " arready"}, n);
    chk({tag, " ar_lat"}, 64'(n), 64'd0);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    w = addr[15:2];
    for (int b = 0; b <= int'(len); b++) begin
      wait_for(3, $sformatf("%s rvalid b%0d", tag, b), n);
      if (b == 0) chk({tag, " r_lat"}, 64'(n), 64'd0);
      chk($sformatf("%s rdata b%0d", tag, b), 64'(RDATA), 64'(exp_mem[w]));
      chk($sformatf("%s rid b%0d", tag, b), 64'(RID), 64'(id));
      chk($sformatf("%s rresp b%0d", tag, b), 64'(RRESP), 64'(resp));
      chk($sformatf("%s rlast b%0d", tag, b), 64'(RLAST), 64'(b == int'(len)));
      @(posedge ACLK); #1;
      w = nxt(w, burst);
    end
    @(negedge ACLK);
    chk({tag, " rvalid_drop"}, 64'(RVALID), 64'd0);
    @(posedge ACLK); #1;
  endtask

  task automatic do_write(input string tag, input logic [7:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst, input int nbeats,
                          input logic [31:0] wbase, input logic [3:0] strb, input logic [1:0] resp);
    int n;
    logic [13:0] w;
    logic [31:0] d;
    AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
    wait_for(1, {tag, " awready"}, n);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    w = addr[15:2];
    for (int b = 0; b < nbeats; b++) begin
      d = wbase + 32'(b);
      WDATA = d; WSTRB = strb; WLAST = (b == nbeats - 1); WVALID = 1'b1;
      wait_for(2, $sformatf("%s wready b%0d", tag, b), n);
      @(posedge ACLK); #1;
      for (int k = 0; k < 4; k++) if (strb[k]) exp_mem[w][8*k +: 8] = d[8*k +: 8];
      w = nxt(w, burst);
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    wait_for(4, {tag, " bvalid"}, n);
    chk({tag, " bid"}, 64'(BID), 64'(id));
    chk({tag, " bresp"}, 64'(BRESP), 64'(resp));
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    @(negedge ACLK);
    chk({tag, " bvalid_drop"}, 64'(BVALID), 64'd0);
    w = addr[15:2];
    for (int b = 0; b < nbeats; b++) begin
      chk($sformatf("%s mem b%0d", tag, b), 64'(sram[w]), 64'(exp_mem[w]));
      w = nxt(w, burst);
    end
    @(posedge ACLK); #1;
  endtask

  initial begin
    int n;
    vecs[0] = '{0, 8'h11, 32'h0000_0010, 4'd0, 2'b01, 32'h0,         4'h0,    2'b00};
    vecs[1] = '{1, 8'h22, 32'h0000_0020, 4'd0, 2'b01, 32'hAABB_CCDD, 4'b0101, 2'b00};
    vecs[2] = '{0, 8'h23, 32'h0000_0020, 4'd0, 2'b01, 32'h0,         4'h0,    2'b00};
    vecs[3] = '{0, 8'h33, 32'h0000_0100, 4'd3, 2'b01, 32'h0,         4'h0,    2'b00};
    vecs[4] = '{1, 8'h44, 32'h0000_0200, 4'd1, 2'b00, 32'h1234_0000, 4'hF,    2'b00};
    vecs[5] = '{0, 8'h45, 32'h0000_0200, 4'd1, 2'b00, 32'h0,         4'h0,    2'b00};
    vecs[6] = '{1, 8'h46, 32'h0000_0300, 4'd1, 2'b10, 32'h5566_0000, 4'hF,    2'b10};
    vecs[7] = '{0, 8'h47, 32'h0000_0300, 4'd1, 2'b11, 32'h0,         4'h0,    2'b10};
    vecs[8] = '{0, 8'h48, 32'h0000_FFFC, 4'd1, 2'b01, 32'h0,         4'h0,    2'b00};

    for (int i = 0; i < DEPTH; i++) exp_mem[i] = pat(i);
    ARESETn = 1'b0; mem_init = 1'b1; bd_we = 1'b0; bd_addr = '0; bd_dat = '0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b0;
    RREADY = 1'b0;
    #1;
    chk_rst("reset");
    repeat (3) @(posedge ACLK);
    #1;
    mem_init = 1'b0;
    ARESETn  = 1'b1;
    @(posedge ACLK); #1;

    // Tie straight out of reset: write first, then the held read, then the new write.
    ARID = 8'h31; ARADDR = 32'h40; ARLEN = 4'd0; ARBURST = 2'b01; ARVALID = 1'b1;
    AWID = 8'h41; AWADDR = 32'h44; AWLEN = 4'd0; AWBURST = 2'b01; AWVALID = 1'b1;
    @(negedge ACLK);
    chk("tie1 awready", 64'(AWREADY), 64'd1);
    chk("tie1 arready", 64'(ARREADY), 64'd0);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WDATA = 32'hDEAD_0001; WSTRB = 4'hF; WLAST = 1'b1; WVALID = 1'b1;
    @(negedge ACLK);
    chk("tie1 wready", 64'(WREADY), 64'd1);
    chk("tie1 arready_busy", 64'(ARREADY), 64'd0);
    @(posedge ACLK); #1;
    exp_mem[14'h11] = 32'hDEAD_0001;
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    AWID = 8'h42; AWADDR = 32'h48; AWVALID = 1'b1;
    @(negedge ACLK);
    chk("tie1 bvalid", 64'(BVALID), 64'd1);
    chk("tie1 bid", 64'(BID), 64'h41);
    chk("tie1 bresp", 64'(BRESP), 64'd0);
    @(posedge ACLK); #1;
    BREADY = 1'b0;
    @(negedge ACLK);
    chk("tie2 arready", 64'(ARREADY), 64'd1);
    chk("tie2 awready", 64'(AWREADY), 64'd0);
    @(posedge ACLK); #1;
    ARVALID = 1'b0; RREADY = 1'b1;
    @(negedge ACLK);
    chk("tie2 rvalid", 64'(RVALID), 64'd1);
    chk("tie2 rdata", 64'(RDATA), 64'(exp_mem[14'h10]));
    chk("tie2 rid", 64'(RID), 64'h31);
    chk("tie2 rlast", 64'(RLAST), 64'd1);
    @(posedge ACLK); #1;
    chk("tie1 mem", 64'(sram[14'h11]), 64'hDEAD_0001);
    do_write("tie3", 8'h42, 32'h48, 4'd0, 2'b01, 1, 32'hDEAD_0002, 4'hF, 2'b00);

    // Preload word 8 so the strobe merge lands on known bytes.
    bd_we = 1'b1; bd_addr = 14'd8; bd_dat = 32'h1122_3344;
    @(posedge ACLK); #1;
    bd_we = 1'b0;
    exp_mem[8] = 32'h1122_3344;

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].wr)
        do_write($sformatf("vec%0d", v), vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].burst,
                 int'(vecs[v].len) + 1, vecs[v].wdata, vecs[v].strb, vecs[v].resp);
      else
        do_read($sformatf("vec%0d", v), vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].burst,
                vecs[v].resp);
    end
    chk("strb merge word8", 64'(sram[8]), 64'h11BB_33DD);

    // 4-beat INCR read with RREADY dropped for two cycles on beat 1.
    ARID = 8'h77; ARADDR = 32'h100; ARLEN = 4'd3; ARBURST = 2'b01; ARVALID = 1'b1; RREADY = 1'b1;
    wait_for(0, "bp arready", n);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    wait_for(3, "bp rvalid b0", n);
    chk("bp rdata b0", 64'(RDATA), 64'(exp_mem[14'h40]));
    chk("bp rlast b0", 64'(RLAST), 64'd0);
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge ACLK);
      chk($sformatf("bp stall%0d rvalid", k), 64'(RVALID), 64'd1);
      chk($sformatf("bp stall%0d rdata", k), 64'(RDATA), 64'(exp_mem[14'h41]));
      chk($sformatf("bp stall%0d rlast", k), 64'(RLAST), 64'd0);
      @(posedge ACLK); #1;
    end
    RREADY = 1'b1;
    for (int b = 1; b < 4; b++) begin
      wait_for(3, $sformatf("bp rvalid b%0d", b), n);
      chk($sformatf("bp rdata b%0d", b), 64'(RDATA), 64'(exp_mem[14'h40 + 14'(b)]));
      chk($sformatf("bp rlast b%0d", b), 64'(RLAST), 64'(b == 3));
      @(posedge ACLK); #1;
    end
    @(negedge ACLK);
    chk("bp rvalid_drop", 64'(RVALID), 64'd0);
    @(posedge ACLK); #1;

    // Short write: LEN=3 but WLAST on the second beat.
    do_write("short", 8'h55, 32'h400, 4'd3, 2'b01, 2, 32'h7000_0000, 4'hF, 2'b10);
    chk("short untouched", 64'(sram[14'h102]), 64'(pat(14'h102)));
    do_read("short_rd", 8'h56, 32'h400, 4'd1, 2'b01, 2'b00);

    // Reset in the middle of an 8-beat write, after three beats have landed.
    AWID = 8'h66; AWADDR = 32'h500; AWLEN = 4'd7; AWBURST = 2'b01; AWVALID = 1'b1;
    wait_for(1, "rst awready", n);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int b = 0; b < 3; b++) begin
      WDATA = 32'hE000_0000 + 32'(b); WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
      wait_for(2, $sformatf("rst wready b%0d", b), n);
      @(posedge ACLK); #1;
      exp_mem[14'h140 + 14'(b)] = 32'hE000_0000 + 32'(b);
    end
    WDATA = 32'hE000_0003; WVALID = 1'b1; AWVALID = 1'b1; ARVALID = 1'b1; ARADDR = 32'h600;
    #2;
    ARESETn = 1'b0;
    #1;
    chk_rst("midrst");
    repeat (3) @(posedge ACLK);
    #1;
    for (int k = 0; k < 8; k++)
      chk($sformatf("midrst mem w%0d", k), 64'(sram[14'h140 + 14'(k)]), 64'(exp_mem[14'h140 + 14'(k)]));
    chk("midrst w3 pattern", 64'(sram[14'h143]), 64'(pat(14'h143)));
    WVALID = 1'b0; AWVALID = 1'b0; ARVALID = 1'b0;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    do_read("post_rst_rd", 8'h67, 32'h500, 4'd3, 2'b01, 2'b00);
    do_write("post_rst_wr", 8'h68, 32'h600, 4'd0, 2'b01, 1, 32'hCAFE_F00D, 4'hF, 2'b00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
